hazard_ctrl: RTL

Pipeline hazard and interrupt sequencer that drives the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers. It watches the instruction leaving decode and the instruction held in ID/EX, and produces load-use stalls and branch/jump flushes. It also owns the interrupt-acceptance state machine that injects an exception entry at a safe decode slot. It includes saturating stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Load-use stall / branch-jump flush generation, interrupt acceptance sequencer
// and saturating stall/flush performance counters for the IF/ID and ID/EX registers.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [2:0]       id_pcsrc,
  input  logic             id_kernel,
  input  logic             id_eret,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rt,
  input  logic [2:0]       ex_pcsrc,
  input  logic             ex_br_taken,
  input  logic             irq,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             irq_take,
  output logic             irq_pending,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {ST_NORMAL, ST_WAIT, ST_KERNEL} state_t;

  state_t state;
  logic   br;
  logic   lu;
  logic   jmp;
  logic   safe;

  always_comb begin
    br   = (ex_pcsrc == 3'd1) && ex_br_taken;
    lu   = ex_memrd && (ex_rt != '0) &&
           ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    jmp  = (id_pcsrc == 3'd2) || (id_pcsrc == 3'd3);
    safe = !br && !lu && (id_pcsrc == 3'd0) && !id_kernel;

    irq_take    = (state == ST_WAIT) && safe;
    // Pending drops in the take cycle: the request is being consumed, not waiting.
    irq_pending = (state == ST_WAIT) && !safe;

    stall      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (br) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (lu) begin
      stall      = 1'b1;
      flush_idex = 1'b1;
    end else if (jmp) begin
      flush_ifid = 1'b1;
    end
    if (irq_take) flush_ifid = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_NORMAL;
    end else begin
      case (state)
        ST_NORMAL: if (irq && !id_kernel) state <= ST_WAIT;
        ST_WAIT:   if (safe) state <= ST_KERNEL;
        ST_KERNEL: if (id_eret && !stall) state <= ST_NORMAL;
        default:   state <= ST_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_ifid || flush_idex) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
